// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive path and its TX
// counterpart.
//   rx_state_t       receiver FSM states
//   PAR_NONE/EVEN/ODD parity mode encodings used by the PARITY parameter
//   parity_bit()     expected parity bit for a word (zero-extend to 9 bits)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int MAX_DATA_BIT = 9;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BIT-1:0] data,
                                        input int mode);
        if (mode == PAR_EVEN) return ^data;
        if (mode == PAR_ODD)  return ~^data;
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, per-bit oversampling counter and
// 3-sample majority vote.
//   clk, reset       block clock, synchronous active-high reset
//   rxd              raw serial line (asynchronous, idles high)
//   sample_tick      one-clk pulse at OVERSAMPLE x baud
//   restart          load the counter with 1 on this tick (start edge seen)
//   rxs              synchronised line
//   bit_val          majority of the samples at counts M-1, M, M+1
//   bit_strobe       tick at count M+1, bit_val is valid
//   bit_end          tick at count OVERSAMPLE-1, last tick of the bit period
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    input  logic sample_tick,
    input  logic restart,
    output logic rxs,
    output logic bit_val,
    output logic bit_strobe,
    output logic bit_end
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] CNT_S0  = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1  = CW'(M);
    localparam logic [CW-1:0] CNT_S2  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

    logic          rx_meta_q;
    logic          rxs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s0_q, s1_q;

    // Counter wraps naturally because OVERSAMPLE is a power of two.
    always_comb begin
        cnt_d = cnt_q;
        if (sample_tick) begin
            cnt_d = restart ? CW'(1) : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
            cnt_q     <= cnt_d;
            if (sample_tick && cnt_q == CNT_S0) s0_q <= rxs_q;
            if (sample_tick && cnt_q == CNT_S1) s1_q <= rxs_q;
        end
    end

    // Third sample is the live line value on the resolving tick.
    assign rxs        = rxs_q;
    assign bit_val    = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign bit_strobe = sample_tick && (cnt_q == CNT_S2);
    assign bit_end    = sample_tick && (cnt_q == CNT_END);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with parity/framing/break/overrun
// detection and a one-entry valid/ready holding register.
//   clk, reset       block clock, synchronous active-high reset
//   rxd              serial line, sample_tick oversampling strobe
//   data_out         held word (LSB first on the line)
//   data_valid       holding register full; data_ready accepts it
//   parity_err       parity mismatch of the held word
//   frame_err        a stop bit of the held word was sampled 0
//   overrun          pulse: completed frame dropped, register still full
//   break_det        pulse: break frame detected, word discarded
//   busy             receiver not idle
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a low sample on a tick
// ST_START     | verifying start bit, false start returns to idle
// ST_DATA      | shifting in DATA_BIT data bits, LSB first
// ST_PARITY    | checking the parity bit
// ST_STOP      | checking stop bit(s), frame completes mid last stop bit
// ST_BRK_WAIT  | break seen, waiting for the line to return high
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BIT   = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BIT   = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rxd,
    input  logic                sample_tick,
    output logic [DATA_BIT-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic                break_det,
    output logic                busy
);
    localparam int BCW = $clog2(DATA_BIT);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BIT - 1);
    localparam logic           LAST_STOP = 1'(STOP_BIT - 1);
    localparam bit             HAS_PAR   = (PARITY != PAR_NONE);

    logic rxs, bit_val, bit_strobe, bit_end, restart;

    rx_state_t            state_q, state_d;
    logic [DATA_BIT-1:0]  shreg_q, shreg_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BIT-1:0]  data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;
    logic                 frame_done;

    assign restart = (state_q == ST_IDLE) && sample_tick && !rxs;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .sample_tick(sample_tick),
        .restart    (restart),
        .rxs        (rxs),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        par_bit_d    = par_bit_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        break_d      = 1'b0;
        frame_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (restart) begin
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    par_bit_d  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_strobe && bit_val) state_d = ST_IDLE;
                else if (bit_end)          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe) shreg_d = {bit_val, shreg_q[DATA_BIT-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe) begin
                    par_bit_d = bit_val;
                    if (bit_val != parity_bit(MAX_DATA_BIT'(shreg_q), PARITY)) perr_d = 1'b1;
                end
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    if (!bit_val) ferr_d = 1'b1;
                    // Completing mid-bit leaves half a bit to catch the next start edge.
                    if (stop_cnt_q == LAST_STOP) begin
                        if (shreg_q == '0 && (!HAS_PAR || !par_bit_q) && !bit_val) begin
                            break_d = 1'b1;
                            state_d = ST_BRK_WAIT;
                        end else begin
                            frame_done = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end else if (bit_end) begin
                    stop_cnt_d = 1'b1;
                end
            end
            ST_BRK_WAIT: begin
                if (sample_tick && rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A simultaneous accept frees the register, so a new word can load in the same cycle.
        if (frame_done && (!data_valid_q || data_ready)) begin
            data_out_d   = shreg_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q | ~bit_val;
            data_valid_d = 1'b1;
        end else begin
            if (frame_done) overrun_d = 1'b1;
            if (data_valid_q && data_ready) data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            par_bit_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            par_bit_q    <= par_bit_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
